// File: rtl/slice_pkg.sv
// Shared types, encodings and frame-layout helpers for the logic slice.
package slice_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  // Carry-in source select; both 00 and 11 route the external Ci.
  localparam logic [1:0] CI_SEL_EXT  = 2'b00;
  localparam logic [1:0] CI_SEL_ZERO = 2'b01;
  localparam logic [1:0] CI_SEL_ONE  = 2'b10;
  localparam logic [1:0] CI_SEL_EXT2 = 2'b11;

  // Config bits per LUT: table A, table B, split bit.
  function automatic int unsigned lut_cfg_bits(input int unsigned s);
    return 2 * (32'd1 << s) + 1;
  endfunction

  // Whole frame: all LUTs, use_cc, 2-bit ci_sel, one reg_sel bit per output.
  function automatic int unsigned cfg_bits(input int unsigned s, input int unsigned n);
    return n * lut_cfg_bits(s) + 1 + 2 + 2 * n;
  endfunction

  function automatic int unsigned lut_off(input int unsigned s, input int unsigned i);
    return i * lut_cfg_bits(s);
  endfunction

  function automatic int unsigned use_cc_off(input int unsigned s, input int unsigned n);
    return n * lut_cfg_bits(s);
  endfunction

  function automatic int unsigned ci_sel_off(input int unsigned s, input int unsigned n);
    return use_cc_off(s, n) + 1;
  endfunction

  function automatic int unsigned reg_sel_off(input int unsigned s, input int unsigned n);
    return use_cc_off(s, n) + 3;
  endfunction

endpackage

// File: rtl/slicel_cfgchain_if.sv
// Serial configuration chain bundle between a loader and a slice.
interface slicel_cfgchain_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_din;
  logic cfg_dout;
  logic cfg_busy;
  logic cfg_loaded;

  modport master (
    output cfg_start, cfg_valid, cfg_din,
    input  cfg_dout, cfg_busy, cfg_loaded
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_din,
    output cfg_dout, cfg_busy, cfg_loaded
  );
endinterface

// File: rtl/lut_frac.sv
// One fracturable LUT: two S-input tables, or one (S+1)-input function on o0.
module lut_frac
  import slice_pkg::*;
#(
  parameter int unsigned S = 4
) (
  input  logic [2*S-1:0]               addr,
  input  logic [lut_cfg_bits(S)-1:0]   cfg,
  output logic                         o0,
  output logic                         o1
);
  localparam int unsigned T = 32'd1 << S;

  logic [S-1:0] a;
  logic [S-1:0] b;
  logic [T-1:0] tbl_a;
  logic [T-1:0] tbl_b;
  logic         split;

  // Table lookup; when not split, address bit S picks table B for the low half.
  always_comb begin
    a     = addr[S-1:0];
    b     = addr[2*S-1:S];
    tbl_a = cfg[T-1:0];
    tbl_b = cfg[2*T-1:T];
    split = cfg[2*T];
    o1    = tbl_b[b];
    if (split) o0 = tbl_a[a];
    else       o0 = addr[S] ? tbl_b[a] : tbl_a[a];
  end
endmodule

// File: rtl/slicel_cfgchain.sv
// Logic slice with carry chain, output registers and a double-buffered
// serial configuration frame loaded on the fabric clock.
module slicel_cfgchain
  import slice_pkg::*;
#(
  parameter int unsigned S_XX_BASE = 4,
  parameter int unsigned NUM_LUTS  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [2*S_XX_BASE*NUM_LUTS-1:0]  luts_in,
  input  logic                             Ci,
  input  logic                             reg_ce,
  slicel_cfgchain_if.slave                 cfg,
  output logic                             Co,
  output logic [2*NUM_LUTS-1:0]            out,
  output logic [2*NUM_LUTS-1:0]            sync_out
);
  localparam int unsigned LUT_CFG     = lut_cfg_bits(S_XX_BASE);
  localparam int unsigned CFG_BITS    = cfg_bits(S_XX_BASE, NUM_LUTS);
  localparam int unsigned USE_CC_OFF  = use_cc_off(S_XX_BASE, NUM_LUTS);
  localparam int unsigned CI_SEL_OFF  = ci_sel_off(S_XX_BASE, NUM_LUTS);
  localparam int unsigned REG_SEL_OFF = reg_sel_off(S_XX_BASE, NUM_LUTS);
  localparam int unsigned CNT_W       = $clog2(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

  cfg_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CFG_BITS-1:0]   shadow_q, shadow_d;
  logic [CFG_BITS-1:0]   active_q, active_d;
  logic                  loaded_q, loaded_d;
  logic [2*NUM_LUTS-1:0] sync_q, sync_d;

  logic [NUM_LUTS-1:0]   p;
  logic [NUM_LUTS-1:0]   g;
  logic [2*NUM_LUTS-1:0] v;
  logic [2*NUM_LUTS-1:0] reg_sel;
  logic [1:0]            ci_sel;
  logic                  use_cc;
  logic                  carry;
  logic                  co_c;

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
    lut_frac #(.S(S_XX_BASE)) u_lut (
      .addr (luts_in[2*S_XX_BASE*i +: 2*S_XX_BASE]),
      .cfg  (active_q[LUT_CFG*i +: LUT_CFG]),
      .o0   (p[i]),
      .o1   (g[i])
    );
  end

  // Load FSM: shift into shadow, then copy shadow to active in one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    loaded_d = loaded_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cfg.cfg_valid) begin
          shadow_d = {cfg.cfg_din, shadow_q[CFG_BITS-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = COMMIT;
            cnt_d   = '0;
          end
        end
        // Restart wins over completion; the bit in this cycle is still shifted.
        if (cfg.cfg_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry chain and combinational output value, forced low until configured.
  always_comb begin
    use_cc  = active_q[USE_CC_OFF];
    ci_sel  = active_q[CI_SEL_OFF +: 2];
    reg_sel = active_q[REG_SEL_OFF +: 2*NUM_LUTS];
    v       = '0;
    case (ci_sel)
      CI_SEL_ZERO: carry = 1'b0;
      CI_SEL_ONE:  carry = 1'b1;
      default:     carry = Ci;
    endcase
    for (int unsigned i = 0; i < NUM_LUTS; i++) begin
      v[2*i]   = use_cc ? (p[i] ^ carry) : p[i];
      v[2*i+1] = g[i];
      carry    = p[i] ? carry : g[i];
    end
    co_c = carry;
    if (!loaded_q) begin
      v    = '0;
      co_c = 1'b0;
    end
  end

  // Per-output register/bypass mux and output register next value.
  always_comb begin
    sync_d = reg_ce ? v : sync_q;
    out    = '0;
    for (int unsigned k = 0; k < 2*NUM_LUTS; k++) begin
      out[k] = reg_sel[k] ? sync_q[k] : v[k];
    end
    if (!loaded_q) out = '0;
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      loaded_q <= loaded_d;
      sync_q   <= sync_d;
    end
  end

  assign Co             = co_c;
  assign sync_out       = sync_q;
  assign cfg.cfg_dout   = shadow_q[0];
  assign cfg.cfg_busy   = (state_q != IDLE);
  assign cfg.cfg_loaded = loaded_q;
endmodule

// File: tb/tb_slicel_cfgchain.sv
// Directed bench for slicel_cfgchain with S_XX_BASE=2, NUM_LUTS=2 (25-bit frame).
module tb_slicel_cfgchain;
  // Frame = {reg_sel[3:0], ci_sel[1:0], use_cc, lut1[8:0], lut0[8:0]}
  // LUT cfg = {split, B[3:0], A[3:0]}
  localparam logic [8:0]  LUT_ANDXOR = 9'b1_0110_1000;  // A=AND, B=XOR, split
  localparam logic [8:0]  LUT_ADD    = 9'b1_1000_0110;  // A=XOR (P), B=AND (G), split
  localparam logic [24:0] F2  = {4'b0000, 2'b00, 1'b0, 9'b0, LUT_ANDXOR};
  localparam logic [24:0] F3A = {4'b0000, 2'b00, 1'b1, LUT_ADD, LUT_ADD};
  localparam logic [24:0] F3B = {4'b0000, 2'b10, 1'b1, LUT_ADD, LUT_ADD};
  localparam logic [24:0] F3C = {4'b0000, 2'b01, 1'b1, LUT_ADD, LUT_ADD};
  localparam logic [24:0] F4  = {4'b1111, 2'b00, 1'b1, LUT_ADD, LUT_ADD};

  logic       clk;
  logic       rst_n;
  logic [7:0] luts_in;
  logic       Ci;
  logic       reg_ce;
  logic       Co;
  logic [3:0] out;
  logic [3:0] sync_out;

  logic [63:0] dlog;
  int          dcnt;
  int          n_cmp;
  int          n_err;

  slicel_cfgchain_if cfg_bus ();

  slicel_cfgchain #(.S_XX_BASE(2), .NUM_LUTS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .luts_in  (luts_in),
    .Ci       (Ci),
    .reg_ce   (reg_ce),
    .cfg      (cfg_bus),
    .Co       (Co),
    .out      (out),
    .sync_out (sync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    cfg_bus.cfg_start = 1'b1;
    step();
    cfg_bus.cfg_start = 1'b0;
  endtask

  // Shift n bits of f starting at index first; logs cfg_dout seen with each bit.
  task automatic send_bits(input logic [24:0] f, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      cfg_bus.cfg_din   = f[i];
      cfg_bus.cfg_valid = 1'b1;
      dlog[dcnt]        = cfg_bus.cfg_dout;
      dcnt++;
      step();
    end
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_din   = 1'b0;
  endtask

  task automatic load(input logic [24:0] f, input logic was_loaded, input string nm);
    pulse_start();
    check_eq({nm, "_busy_after_start"}, 32'(cfg_bus.cfg_busy), 32'd1);
    send_bits(f, 0, 25);
    check_eq({nm, "_loaded_at_last_bit"}, 32'(cfg_bus.cfg_loaded), 32'(was_loaded));
    check_eq({nm, "_busy_in_commit"}, 32'(cfg_bus.cfg_busy), 32'd1);
    step();
    check_eq({nm, "_loaded_after_commit"}, 32'(cfg_bus.cfg_loaded), 32'd1);
    check_eq({nm, "_busy_after_commit"}, 32'(cfg_bus.cfg_busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    dcnt  = 0;
    dlog  = '0;
    rst_n = 1'b0;
    luts_in = 8'h00;
    Ci = 1'b0;
    reg_ce = 1'b0;
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_din   = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // 1: unconfigured slice is silent
    luts_in = 8'hFF;
    Ci = 1'b1;
    #1;
    check_eq("s1_out", 32'(out), 32'h0);
    check_eq("s1_sync", 32'(sync_out), 32'h0);
    check_eq("s1_co", 32'(Co), 32'h0);
    check_eq("s1_loaded", 32'(cfg_bus.cfg_loaded), 32'h0);
    check_eq("s1_busy", 32'(cfg_bus.cfg_busy), 32'h0);
    reg_ce = 1'b1;
    step();
    reg_ce = 1'b0;
    check_eq("s1_sync_capture", 32'(sync_out), 32'h0);

    // 2: AND / XOR in split mode
    Ci = 1'b0;
    luts_in = 8'h00;
    load(F2, 1'b0, "s2");
    luts_in = 8'h07;
    #1;
    check_eq("s2_out_0111", 32'(out), 32'h3);
    check_eq("s2_co", 32'(Co), 32'h0);
    luts_in = 8'h09;
    #1;
    check_eq("s2_out_1001", 32'(out), 32'h2);

    // 3: two-bit adder through the carry chain
    load(F3A, 1'b1, "s3a");
    luts_in = 8'hAF;
    Ci = 1'b0;
    #1;
    check_eq("s3a_out_3p1", 32'(out), 32'h2);
    check_eq("s3a_co_3p1", 32'(Co), 32'h1);
    luts_in = 8'h0F;
    Ci = 1'b1;
    #1;
    check_eq("s3a_out_1p1c", 32'(out), 32'h7);
    check_eq("s3a_co_1p1c", 32'(Co), 32'h0);
    load(F3B, 1'b1, "s3b");
    luts_in = 8'hAF;
    Ci = 1'b0;
    #1;
    check_eq("s3b_out_ci1", 32'(out), 32'h3);
    check_eq("s3b_co_ci1", 32'(Co), 32'h1);
    load(F3C, 1'b1, "s3c");
    Ci = 1'b1;
    #1;
    check_eq("s3c_out_ci0", 32'(out), 32'h2);
    check_eq("s3c_co_ci0", 32'(Co), 32'h1);

    // 4: registered outputs honour reg_ce
    load(F4, 1'b1, "s4");
    luts_in = 8'hAF;
    Ci = 1'b0;
    reg_ce = 1'b1;
    step();
    reg_ce = 1'b0;
    check_eq("s4_sync_first", 32'(sync_out), 32'h2);
    check_eq("s4_out_first", 32'(out), 32'h2);
    luts_in = 8'h0F;
    Ci = 1'b1;
    #1;
    check_eq("s4_out_hold_comb", 32'(out), 32'h2);
    step();
    check_eq("s4_out_hold_edge", 32'(out), 32'h2);
    reg_ce = 1'b1;
    #1;
    check_eq("s4_out_before_edge", 32'(out), 32'h2);
    step();
    reg_ce = 1'b0;
    check_eq("s4_out_updated", 32'(out), 32'h7);
    check_eq("s4_sync_updated", 32'(sync_out), 32'h7);

    // 5: reload while running, with a restart part-way
    dcnt = 0;
    dlog = '0;
    pulse_start();
    send_bits(F2, 0, 10);
    pulse_start();
    send_bits(F2, 0, 24);
    check_eq("s5_busy_after_restart", 32'(cfg_bus.cfg_busy), 32'h1);
    check_eq("s5_old_out_mid", 32'(out), 32'h7);
    send_bits(F2, 24, 1);
    check_eq("s5_old_out_at_last", 32'(out), 32'h7);
    check_eq("s5_busy_commit", 32'(cfg_bus.cfg_busy), 32'h1);
    step();
    check_eq("s5_new_out", 32'(out), 32'h1);
    check_eq("s5_busy_done", 32'(cfg_bus.cfg_busy), 32'h0);
    check_eq("s5_dout_prev_frame", 32'(dlog[24:0]), 32'(F4));

    // 6: reset in the middle of a shift, then a clean load
    pulse_start();
    send_bits(F3A, 0, 12);
    rst_n = 1'b0;
    step();
    check_eq("s6_busy", 32'(cfg_bus.cfg_busy), 32'h0);
    check_eq("s6_loaded", 32'(cfg_bus.cfg_loaded), 32'h0);
    check_eq("s6_out", 32'(out), 32'h0);
    check_eq("s6_sync", 32'(sync_out), 32'h0);
    check_eq("s6_dout", 32'(cfg_bus.cfg_dout), 32'h0);
    check_eq("s6_co", 32'(Co), 32'h0);
    rst_n = 1'b1;
    luts_in = 8'h07;
    Ci = 1'b0;
    load(F2, 1'b0, "s6l");
    #1;
    check_eq("s6_out_reload", 32'(out), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
